multi_pwr_ctrl: RTL and testbench
=================================

MULTI_PWR_CTRL -- requirements
Module: multi_pwr_ctrl

Interface
REQ-001 The block SHALL have parameter NUM_DOM, default 4, giving the number of independent power domains (legal range 2..16).
REQ-002 The block SHALL have parameter CNT_W, default 4, giving the width of each dwell counter and dwell register.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 idle  input  NUM_DOM  per-domain idle indication from the tx/rx blocks.
REQ-006 wake  input  NUM_DOM  per-domain wake request.
REQ-007 csr_busy  input  1  register traffic in progress; blocks new power-down entry in all domains.
REQ-008 pwr_ack  input  NUM_DOM  per-domain power-switch acknowledge; used only when PWR_CTRL_ACK_EN is defined.
REQ-009 reg_wr  input  1  configuration write strobe.
REQ-010 reg_sel  input  $clog2(NUM_DOM)  index of the domain targeted by the write.
REQ-011 reg_data  input  CNT_W+1  write data: bit CNT_W is en, bits CNT_W-1:0 are dwell.
REQ-012 pwr_up, iso_on, save, restore, dom_off  output  NUM_DOM each  registered per-domain low-power controls and status.

Function
REQ-013 Each domain SHALL run its own FSM with states ACTIVE, ISO, SAVE, OFF, PWRON and RESTORE.
REQ-014 On reg_wr, en[reg_sel] and dwell[reg_sel] SHALL load from reg_data at the next edge; writes with reg_sel >= NUM_DOM SHALL be ignored.
REQ-015 ACTIVE->ISO SHALL occur when en & idle & ~wake & ~csr_busy all hold for that domain; otherwise the domain stays ACTIVE.
REQ-016 ISO->ACTIVE SHALL occur when wake or ~en holds (abort); otherwise ISO->SAVE when cnt >= dwell.
REQ-017 SAVE->OFF SHALL occur when cnt >= dwell; wake and en are ignored while in SAVE.
REQ-018 OFF->PWRON SHALL occur when (wake | ~en) holds and the domain wins power-up arbitration.
REQ-019 Power-up arbitration: at most one domain in PWRON at any time. Among requesting OFF domains, the lowest index wins, granted only when no domain is already in PWRON; losers stay OFF.
REQ-020 PWRON->RESTORE timing: without PWR_CTRL_ACK_EN, when cnt >= dwell; with it, see REQ-030.
REQ-021 RESTORE->ACTIVE SHALL occur when cnt >= dwell.
REQ-022 Per-domain cnt SHALL clear to 0 on every state change and in ACTIVE/OFF.
REQ-023 In timed states, cnt SHALL increment by 1 while cnt < dwell and then hold (no wrap), so a timed state lasts dwell+1 cycles and dwell=0 gives exactly 1 cycle.
REQ-024 A dwell rewrite mid-state SHALL take effect on the next compare; if cnt already >= the new dwell, the state exits at the next edge.
REQ-025 Outputs SHALL be registered decodes of the current state, lagging the state by one cycle:
- pwr_up = state != OFF
- iso_on = state != ACTIVE
- save = state == SAVE
- restore = state == RESTORE
- dom_off = state == OFF

Reset
REQ-026 While reset is asserted, every domain SHALL be in ACTIVE with cnt = 0, en = 0 and dwell = all ones.
REQ-027 While reset is asserted, the outputs SHALL be pwr_up = all ones, and iso_on, save, restore and dom_off = all zeros.
REQ-028 Reset asserted mid-sequence (including OFF) SHALL force these values asynchronously, with no save or restore pulse emitted.

Configuration
REQ-029 Macro PWR_CTRL_ACK_EN SHALL select the PWRON exit condition.
REQ-030 With PWR_CTRL_ACK_EN defined, PWRON->RESTORE SHALL occur on the first edge where pwr_ack[i] = 1, independent of dwell; cnt still runs and saturates but is not compared.
REQ-031 Without PWR_CTRL_ACK_EN, pwr_ack SHALL be unused and PWRON SHALL exit on the dwell compare (REQ-020).

Verification
REQ-032 Full cycle: dom0 en=1, dwell=2, idle0=1, wake0 pulsed once dom_off[0]=1 -> iso_on rises 1 cycle after the idle edge; save high 3 cycles; dom_off high until wake; restore high 3 cycles; iso_on and save low again; no X.
REQ-033 Abort: wake0=1 during ISO -> return to ACTIVE; save never asserts; pwr_up stays 1.
REQ-034 Arbitration: dom1 and dom2 both OFF, wake both in same cycle -> dom1 enters PWRON first; dom2 stays OFF (dom_off[2]=1) until dom1 reaches RESTORE.
REQ-035 Blocking and boundaries:
- csr_busy=1 with all idle=1 -> no domain leaves ACTIVE.
- dwell=0 -> ISO, SAVE, PWRON and RESTORE each last 1 cycle.
- dwell=15 (CNT_W=4) -> cnt saturates at 15, no wrap.
REQ-036 Reset mid-OFF: assert reset while dom_off[0]=1 -> pwr_up[0]=1 and dom_off[0]=0 immediately; en=0, so no re-entry after release.
REQ-037 PWR_CTRL_ACK_EN build: dwell=15, pwr_ack[0] asserted 2 cycles into PWRON -> RESTORE entered on the next edge; without the macro the same stimulus stays 16 cycles in PWRON.

Source files
------------

// File: rtl/multi_pwr_ctrl.sv
// ============================================================================
// Module      : multi_pwr_ctrl
// Description : Per-domain power sequencer (ACTIVE/ISO/SAVE/OFF/PWRON/RESTORE)
//               with single-grant power-up arbitration.
//               Optional macro PWR_CTRL_ACK_EN: PWRON exits on pwr_ack.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module multi_pwr_ctrl #(
    parameter int NUM_DOM = 4,
    parameter int CNT_W   = 4
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [NUM_DOM-1:0]         idle,
    input  logic [NUM_DOM-1:0]         wake,
    input  logic                       csr_busy,
    input  logic [NUM_DOM-1:0]         pwr_ack,
    input  logic                       reg_wr,
    input  logic [$clog2(NUM_DOM)-1:0] reg_sel,
    input  logic [CNT_W:0]             reg_data,
    output logic [NUM_DOM-1:0]         pwr_up,
    output logic [NUM_DOM-1:0]         iso_on,
    output logic [NUM_DOM-1:0]         save,
    output logic [NUM_DOM-1:0]         restore,
    output logic [NUM_DOM-1:0]         dom_off
);

    localparam logic [2:0] S_ACTIVE  = 3'd0;
    localparam logic [2:0] S_ISO     = 3'd1;
    localparam logic [2:0] S_SAVE    = 3'd2;
    localparam logic [2:0] S_OFF     = 3'd3;
    localparam logic [2:0] S_PWRON   = 3'd4;
    localparam logic [2:0] S_RESTORE = 3'd5;

    logic [NUM_DOM-1:0][2:0]       r_state;
    logic [NUM_DOM-1:0][CNT_W-1:0] r_cnt;
    logic [NUM_DOM-1:0][CNT_W-1:0] r_dwell;
    logic [NUM_DOM-1:0]            r_en;

    logic [NUM_DOM-1:0][2:0]       w_nxt_state;
    logic [NUM_DOM-1:0][CNT_W-1:0] w_nxt_cnt;
    logic [NUM_DOM-1:0]            w_done;
    logic [NUM_DOM-1:0]            w_req;
    logic [NUM_DOM-1:0]            w_grant;
    logic                          w_busy;
    logic                          w_found;

`ifndef PWR_CTRL_ACK_EN
    logic w_unused_ack;
    assign w_unused_ack = ^pwr_ack;
`endif

    // Lowest-index requester wins, but only while no domain is powering up.
    always_comb begin
        w_busy  = 1'b0;
        w_found = 1'b0;
        w_req   = '0;
        w_grant = '0;
        for (int i = 0; i < NUM_DOM; i++) begin
            w_req[i] = (r_state[i] == S_OFF) && (wake[i] || !r_en[i]);
            if (r_state[i] == S_PWRON) begin
                w_busy = 1'b1;
            end
        end
        for (int i = 0; i < NUM_DOM; i++) begin
            if (w_req[i] && !w_found && !w_busy) begin
                w_grant[i] = 1'b1;
                w_found    = 1'b1;
            end
        end
    end

    always_comb begin
        w_nxt_state = r_state;
        w_nxt_cnt   = r_cnt;
        w_done      = '0;
        for (int i = 0; i < NUM_DOM; i++) begin
            w_done[i] = (r_cnt[i] >= r_dwell[i]);
            case (r_state[i])
                S_ACTIVE: begin
                    if (r_en[i] && idle[i] && !wake[i] && !csr_busy) begin
                        w_nxt_state[i] = S_ISO;
                    end
                end
                S_ISO: begin
                    if (wake[i] || !r_en[i]) begin
                        w_nxt_state[i] = S_ACTIVE;
                    end else if (w_done[i]) begin
                        w_nxt_state[i] = S_SAVE;
                    end
                end
                S_SAVE: begin
                    if (w_done[i]) begin
                        w_nxt_state[i] = S_OFF;
                    end
                end
                S_OFF: begin
                    if (w_grant[i]) begin
                        w_nxt_state[i] = S_PWRON;
                    end
                end
                S_PWRON: begin
`ifdef PWR_CTRL_ACK_EN
                    if (pwr_ack[i]) begin
                        w_nxt_state[i] = S_RESTORE;
                    end
`else
                    if (w_done[i]) begin
                        w_nxt_state[i] = S_RESTORE;
                    end
`endif
                end
                S_RESTORE: begin
                    if (w_done[i]) begin
                        w_nxt_state[i] = S_ACTIVE;
                    end
                end
                default: w_nxt_state[i] = S_ACTIVE;
            endcase
            // Saturating dwell counter, restarted on every state change.
            if ((w_nxt_state[i] != r_state[i]) || (r_state[i] == S_ACTIVE) ||
                (r_state[i] == S_OFF)) begin
                w_nxt_cnt[i] = '0;
            end else if (!w_done[i]) begin
                w_nxt_cnt[i] = r_cnt[i] + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= '0;
            r_cnt   <= '0;
            r_en    <= '0;
            r_dwell <= '1;
            pwr_up  <= '1;
            iso_on  <= '0;
            save    <= '0;
            restore <= '0;
            dom_off <= '0;
        end else begin
            r_state <= w_nxt_state;
            r_cnt   <= w_nxt_cnt;
            for (int i = 0; i < NUM_DOM; i++) begin
                if (reg_wr && (int'(reg_sel) == i)) begin
                    r_en[i]    <= reg_data[CNT_W];
                    r_dwell[i] <= reg_data[CNT_W-1:0];
                end
                pwr_up[i]  <= (r_state[i] != S_OFF);
                iso_on[i]  <= (r_state[i] != S_ACTIVE);
                save[i]    <= (r_state[i] == S_SAVE);
                restore[i] <= (r_state[i] == S_RESTORE);
                dom_off[i] <= (r_state[i] == S_OFF);
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_multi_pwr_ctrl.sv
// ============================================================================
// Module      : tb_multi_pwr_ctrl
// Description : Directed self-checking bench for multi_pwr_ctrl.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_multi_pwr_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] idle, wake, pwr_ack;
    logic       csr_busy, reg_wr;
    logic [1:0] reg_sel;
    logic [4:0] reg_data;
    logic [3:0] pwr_up, iso_on, save, restore, dom_off;

    int n_checks = 0;
    int n_fails  = 0;

    // Per-domain output tuple: {pwr_up, iso_on, save, restore, dom_off}
    logic [4:0] c_dn [0:8] = '{5'b10000, 5'b11000, 5'b11000, 5'b11000, 5'b11100,
                               5'b11100, 5'b11100, 5'b01001, 5'b01001};
    logic [4:0] c_up [0:7] = '{5'b01001, 5'b11000, 5'b11000, 5'b11000, 5'b11010,
                               5'b11010, 5'b11010, 5'b10000};
    // {dom2, dom1}
    logic [9:0] c_arb [0:9] = '{10'b10000_10000, 10'b11000_11000, 10'b11100_11100,
                                10'b01001_01001, 10'b01001_01001, 10'b01001_11000,
                                10'b01001_11010, 10'b11000_10000, 10'b11010_10000,
                                10'b10000_10000};

    always #5 clk = ~clk;

    multi_pwr_ctrl #(.NUM_DOM(4), .CNT_W(4)) u_dut (
        .clk      (clk),
        .reset    (reset),
        .idle     (idle),
        .wake     (wake),
        .csr_busy (csr_busy),
        .pwr_ack  (pwr_ack),
        .reg_wr   (reg_wr),
        .reg_sel  (reg_sel),
        .reg_data (reg_data),
        .pwr_up   (pwr_up),
        .iso_on   (iso_on),
        .save     (save),
        .restore  (restore),
        .dom_off  (dom_off)
    );

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fails++;
            $display("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [1:0] sel, input logic en, input logic [3:0] dw);
        reg_wr   = 1'b1;
        reg_sel  = sel;
        reg_data = {en, dw};
        tick();
        reg_wr   = 1'b0;
    endtask

    function automatic logic [4:0] dom(input int i);
        return {pwr_up[i], iso_on[i], save[i], restore[i], dom_off[i]};
    endfunction

    initial begin
        reset = 1'b1; idle = '0; wake = '0; pwr_ack = '0;
        csr_busy = 1'b0; reg_wr = 1'b0; reg_sel = '0; reg_data = '0;
        repeat (2) tick();
        check_val("rst_pwr_up",  32'(pwr_up),  32'hF);
        check_val("rst_iso_on",  32'(iso_on),  32'h0);
        check_val("rst_save",    32'(save),    32'h0);
        check_val("rst_restore", 32'(restore), 32'h0);
        check_val("rst_dom_off", 32'(dom_off), 32'h0);
        reset = 1'b0;
        tick();

        wr(2'd0, 1'b1, 4'd2);
        wr(2'd1, 1'b1, 4'd0);
        wr(2'd2, 1'b1, 4'd0);

        // csr_busy blocks entry in every domain
        csr_busy = 1'b1; idle = 4'hF;
        repeat (4) tick();
        check_val("busy_iso_on",  32'(iso_on),  32'h0);
        check_val("busy_dom_off", 32'(dom_off), 32'h0);
        csr_busy = 1'b0; idle = '0;
        repeat (2) tick();
        check_val("busy_after",   32'(iso_on),  32'h0);

        // full power-down / power-up cycle on domain 0, dwell = 2
        idle = 4'b0001;
        for (int k = 0; k < 9; k++) begin
            tick();
            check_val($sformatf("full_dn%0d", k), 32'(dom(0)), 32'(c_dn[k]));
        end
        wake = 4'b0001; idle = '0;
        for (int k = 0; k < 8; k++) begin
            tick();
            wake = '0;
            check_val($sformatf("full_up%0d", k), 32'(dom(0)), 32'(c_up[k]));
        end

        // abort from ISO
        idle = 4'b0001;
        tick();
        check_val("abort0", 32'(dom(0)), 32'(5'b10000));
        wake = 4'b0001;
        tick();
        check_val("abort1", 32'(dom(0)), 32'(5'b11000));
        tick();
        check_val("abort2", 32'(dom(0)), 32'(5'b10000));
        tick();
        check_val("abort3", 32'(dom(0)), 32'(5'b10000));
        idle = '0; wake = '0;
        tick();

        // dwell = 0 descent on domains 1 and 2, then simultaneous wake
        idle = 4'b0110;
        for (int k = 0; k < 10; k++) begin
            tick();
            check_val($sformatf("arb%0d", k), 32'({dom(2), dom(1)}), 32'(c_arb[k]));
            if (k == 3) begin
                wake = 4'b0110; idle = '0;
            end
        end
        wake = '0;

        // dwell = 15: ISO lasts 16 cycles; then shorten dwell mid-SAVE
        wr(2'd3, 1'b1, 4'd15);
        idle = 4'b1000;
        repeat (16) tick();
        tick();
        check_val("d15_iso_save", 32'({iso_on[3], save[3]}), 32'(2'b10));
        tick();
        check_val("d15_save_on",  32'(save[3]), 32'h1);
        repeat (2) tick();
        wr(2'd3, 1'b1, 4'd2);
        tick();
        check_val("rewrite_hold", 32'(dom_off[3]), 32'h0);
        tick();
        check_val("rewrite_off",  32'(dom_off[3]), 32'h1);
        idle = '0;

        // asynchronous reset while domain 0 is OFF
        idle = 4'b0001;
        repeat (8) tick();
        check_val("pre_rst_off", 32'(dom_off[0]), 32'h1);
        reset = 1'b1;
        #1;
        check_val("arst_pwr_up",  32'(pwr_up),  32'hF);
        check_val("arst_dom_off", 32'(dom_off), 32'h0);
        check_val("arst_iso_on",  32'(iso_on),  32'h0);
        tick();
        reset = 1'b0;
        repeat (4) tick();
        check_val("post_rst_iso", 32'(iso_on),  32'h0);
        check_val("post_rst_off", 32'(dom_off), 32'h0);
        idle = '0;

        // PWRON exit: dwell = 15 with pwr_ack raised two cycles in
        wr(2'd3, 1'b1, 4'd0);
        idle = 4'b1000;
        repeat (4) tick();
        check_val("ack_off", 32'(dom_off[3]), 32'h1);
        wr(2'd3, 1'b1, 4'd15);
        wake = 4'b1000; idle = '0;
        repeat (2) tick();
        pwr_ack = 4'b1000;
        repeat (2) tick();
`ifdef PWR_CTRL_ACK_EN
        check_val("ack_p3",  32'(restore[3]), 32'h1);
`else
        check_val("ack_p3",  32'(restore[3]), 32'h0);
`endif
        repeat (13) tick();
`ifdef PWR_CTRL_ACK_EN
        check_val("ack_p16", 32'(restore[3]), 32'h1);
`else
        check_val("ack_p16", 32'(restore[3]), 32'h0);
`endif
        tick();
        check_val("ack_p17", 32'(restore[3]), 32'h1);
        wake = '0; pwr_ack = '0;
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fails);
        $finish;
    end

endmodule

`default_nettype wire
